match_sequencer: RTL and testbench
==================================

# match_sequencer

Match-level controller for the pong game, clocked in the pixel-clock domain beside `game_control`. It replaces the combinationally derived frame clock with a registered one-cycle `frame_tick_o` enable, and it sequences the match through idle, serve, play, point and game-over phases. It keeps both players' scores and drives the run and ball-reset controls that gate `game_control`.

## Interface

Parameters:
- `WIN_SCORE`, default 7: score that ends the match; range 1..15.
- `SERVE_FRAMES`, default 60: frames the ball is held at centre before play; range 1..255.
- `POINT_FRAMES`, default 90: frames of freeze after a point; range 1..255.

Ports:
- `clk_i`  in  1  pixel clock; the only clock.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start button, active high (already inverted at top); asynchronous to `clk_i`.
- `pos_x_i`  in  10  current pixel x from `vga_sync`.
- `pos_y_i`  in  10  current pixel y from `vga_sync`.
- `miss_left_i`  in  1  left paddle missed; one-cycle pulse, aligned to a `frame_tick_o` cycle.
- `miss_right_i`  in  1  right paddle missed; same format as `miss_left_i`.
- `frame_tick_o`  out  1  one-cycle frame enable.
- `run_o`  out  1  ball and paddle motion enabled.
- `ball_reset_o`  out  1  hold the ball at centre with the start speed.
- `score_l_o`  out  4  left player score.
- `score_r_o`  out  4  right player score.
- `winner_o`  out  2  match result: 00 none, 01 left, 10 right.
- `state_o`  out  3  current state encoding, for debug.

## Operation

- **Frame tick:** `origin` = (`pos_x_i`==0 && `pos_y_i`==0). `frame_tick_o` is registered and pulses one cycle on the rising edge of `origin`, so the pulse is one cycle even if `origin` is held.
- **Start button:** `start_i` passes through a 2-flop synchroniser. `start_rise` = synchronised level AND NOT its previous value.
- **States and transitions:**
  - IDLE: on `start_rise`, clear scores and `winner_o`, go to SERVE.
  - SERVE: the frame counter counts `frame_tick_o`. At `SERVE_FRAMES`, go to PLAY and clear the counter.
  - PLAY:
    - `miss_left_i` alone: `score_r_o`+1, go to POINT.
    - `miss_right_i` alone: `score_l_o`+1, go to POINT.
    - Both in the same cycle: no score change, go to POINT (replayed rally).
  - POINT: count `POINT_FRAMES` ticks. Then go to OVER if either score equals `WIN_SCORE`, else to SERVE.
  - OVER: `winner_o` is set on entry. On `start_rise`, clear scores and `winner_o`, go to SERVE.
- **Ignored inputs:** misses outside PLAY are ignored. `start_rise` in SERVE, PLAY or POINT is ignored (PAUSE build excepted, see Configuration).
- **Score arithmetic:** scores saturate at `WIN_SCORE` and never wrap.
- **Frame counter:** 8-bit, cleared on every state entry, counts only on `frame_tick_o`.
- **Outputs by state:**
  - `run_o`=1 only in PLAY.
  - `ball_reset_o`=1 in IDLE, SERVE, POINT and OVER.

## Timing

- **Reset values:**
  - State IDLE, `frame_tick_o`=0, `run_o`=0, `ball_reset_o`=1.
  - Scores 0, `winner_o`=00, counter 0, synchroniser flops 0.
- **Frame tick latency:** `frame_tick_o` is high the cycle after `origin` is first sampled high.
- **Start latency:** `start_i` rising to state change takes 3 cycles (2 sync flops plus the state register).
- **Miss to outputs:** the cycle after a miss pulse in PLAY, the score is updated, the state is POINT and `run_o`=0.
- **SERVE exit:** the transition happens on the `SERVE_FRAMES`-th tick. `run_o` rises on the following cycle.
- **Output registers:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Reset mid-operation:** asynchronous return to the reset values. Scores are lost, and no tick is emitted during reset.

## Configuration

- **`MATCH_PAUSE_EN` defined:**
  - State PAUSE (encoding 5) is added.
  - `start_rise` in PLAY goes to PAUSE. `start_rise` in PAUSE returns to PLAY.
  - In PAUSE: `run_o`=0, `ball_reset_o`=0, counter frozen, misses ignored.
- **`MATCH_PAUSE_EN` undefined:** PAUSE does not exist and `start_rise` in PLAY is ignored.

## Structure

- **`pong_pkg`** holds:
  - `match_state_e`: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSE=5.
  - `SCORE_W`=4 and `FRAME_CNT_W`=8.
  - The existing `init_speed` and `sync_data` typedefs.
- **Sub-module `start_sync_edge`:** the 2-flop synchroniser plus rising-edge detector. It is reusable for the paddle buttons.

## Test plan

- Reset, then drive `origin` high for 3 cycles → exactly one `frame_tick_o` pulse, 1 cycle after `origin` rises; outputs at reset values beforehand.
- `SERVE_FRAMES`=2: `start_i` pulse → SERVE within 3 cycles. Two frame ticks later → PLAY, `run_o`=1, `ball_reset_o`=0.
- In PLAY, `miss_left_i` pulse → `score_r_o`=1, POINT, `run_o`=0. After `POINT_FRAMES` ticks → SERVE.
- `miss_left_i` and `miss_right_i` together in PLAY → scores unchanged, POINT. A miss pulse during SERVE → ignored.
- `WIN_SCORE`=2: two right-player points → OVER, `winner_o`=10, `score_r_o` stays 2. `start_i` → scores 0, SERVE.
- `MATCH_PAUSE_EN` defined:
  - In PLAY, `start_i` → PAUSE; a miss pulse is ignored.
  - A second `start_i` → PLAY with the counter unchanged.
  - Assert `rst_n_i` low in PAUSE → immediate IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game blocks: match state
// encoding, score / frame-counter widths, and the ball and sync bundles.
package pong_pkg;

    localparam int SCORE_W     = 4;
    localparam int FRAME_CNT_W = 8;

    // Match phases. PAUSE is only reachable when the pause build is enabled.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } match_state_e;

    // Ball launch velocity used when the ball is re-centred.
    typedef struct packed {
        logic signed [3:0] dx;
        logic signed [3:0] dy;
    } init_speed;

    // Raster position and sync strobes produced by vga_sync.
    typedef struct packed {
        logic [9:0] pos_x;
        logic [9:0] pos_y;
        logic       hsync;
        logic       vsync;
        logic       video_on;
    } sync_data;

    // Increment a score but hold it once it has reached the match limit.
    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] s,
        input logic [SCORE_W-1:0] lim
    );
        return (s >= lim) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/start_sync_edge.sv
// Two-flop synchroniser for an asynchronous push button followed by a
// rising-edge detector. Generic enough to reuse for the paddle buttons.
module start_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic [1:0] sync_pipe;
    logic       prev_q;

    // Shift the raw button through two flops, then keep one more copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_pipe <= 2'b00;
            prev_q    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], async_i};
            prev_q    <= sync_pipe[1];
        end
    end

    assign rise_o = sync_pipe[1] & ~prev_q;

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller for pong: registered frame tick, start-button
// handling, serve/play/point/over sequencing and score keeping.
// Optional build macro MATCH_PAUSE_EN adds a PAUSE state toggled by start.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [9:0]  pos_x_i,
    input  logic [9:0]  pos_y_i,
    input  logic        miss_left_i,
    input  logic        miss_right_i,
    output logic        frame_tick_o,
    output logic        run_o,
    output logic        ball_reset_o,
    output logic [3:0]  score_l_o,
    output logic [3:0]  score_r_o,
    output logic [1:0]  winner_o,
    output logic [2:0]  state_o
);

    localparam logic [SCORE_W-1:0]     WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] POINT_LAST = FRAME_CNT_W'(POINT_FRAMES - 1);

    match_state_e           state;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   origin;
    logic                   origin_q;
    logic                   start_rise;

    assign origin  = (pos_x_i == 10'd0) && (pos_y_i == 10'd0);
    assign state_o = state;

    start_sync_edge u_start_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (start_i),
        .rise_o  (start_rise)
    );

    // Frame tick fires once per rising edge of the raster origin, even if origin lingers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            origin_q     <= 1'b0;
            frame_tick_o <= 1'b0;
        end else begin
            origin_q     <= origin;
            frame_tick_o <= origin & ~origin_q;
        end
    end

    // Match FSM; run/ball_reset are updated only on transitions so they stay registered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            run_o        <= 1'b0;
            ball_reset_o <= 1'b1;
            score_l_o    <= '0;
            score_r_o    <= '0;
            winner_o     <= 2'b00;
            frame_cnt    <= '0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        state        <= SERVE;
                        score_l_o    <= '0;
                        score_r_o    <= '0;
                        winner_o     <= 2'b00;
                        frame_cnt    <= '0;
                        run_o        <= 1'b0;
                        ball_reset_o <= 1'b1;
                    end
                end

                SERVE: begin
                    if (frame_tick_o) begin
                        if (frame_cnt == SERVE_LAST) begin
                            state        <= PLAY;
                            frame_cnt    <= '0;
                            run_o        <= 1'b1;
                            ball_reset_o <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                        end
                    end
                end

                PLAY: begin
                    if (miss_left_i || miss_right_i) begin
                        // A double miss is a replayed rally: no score change.
                        state        <= POINT;
                        frame_cnt    <= '0;
                        run_o        <= 1'b0;
                        ball_reset_o <= 1'b1;
                        if (miss_left_i && !miss_right_i)
                            score_r_o <= sat_inc(score_r_o, WIN);
                        else if (miss_right_i && !miss_left_i)
                            score_l_o <= sat_inc(score_l_o, WIN);
`ifdef MATCH_PAUSE_EN
                    end else if (start_rise) begin
                        // Counter keeps its value across the pause.
                        state        <= PAUSE;
                        run_o        <= 1'b0;
                        ball_reset_o <= 1'b0;
`endif
                    end else if (frame_tick_o) begin
                        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                    end
                end

                POINT: begin
                    if (frame_tick_o) begin
                        if (frame_cnt == POINT_LAST) begin
                            frame_cnt <= '0;
                            if (score_l_o == WIN || score_r_o == WIN) begin
                                state    <= OVER;
                                winner_o <= (score_l_o == WIN) ? 2'b01 : 2'b10;
                            end else begin
                                state <= SERVE;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                        end
                    end
                end

`ifdef MATCH_PAUSE_EN
                PAUSE: begin
                    if (start_rise) begin
                        state        <= PLAY;
                        run_o        <= 1'b1;
                        ball_reset_o <= 1'b0;
                    end
                end
`endif

                default: begin
                    state        <= IDLE;
                    frame_cnt    <= '0;
                    run_o        <= 1'b0;
                    ball_reset_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with WIN_SCORE=2, SERVE_FRAMES=2,
// POINT_FRAMES=3. Pause checks are compiled in with MATCH_PAUSE_EN.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       miss_l;
    logic       miss_r;
    logic [9:0] px;
    logic [9:0] py;
    logic       tick;
    logic       run;
    logic       breset;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] S_IDLE  = 0;
    localparam logic [31:0] S_SERVE = 1;
    localparam logic [31:0] S_PLAY  = 2;
    localparam logic [31:0] S_POINT = 3;
    localparam logic [31:0] S_OVER  = 4;
    localparam logic [31:0] S_PAUSE = 5;

    match_sequencer #(
        .WIN_SCORE    (2),
        .SERVE_FRAMES (2),
        .POINT_FRAMES (3)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .pos_x_i      (px),
        .pos_y_i      (py),
        .miss_left_i  (miss_l),
        .miss_right_i (miss_r),
        .frame_tick_o (tick),
        .run_o        (run),
        .ball_reset_o (breset),
        .score_l_o    (score_l),
        .score_r_o    (score_r),
        .winner_o     (winner),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One raster origin: tick goes high after the first edge, FSM consumes it on the second.
    task automatic frame();
        px = 10'd0; py = 10'd0;
        cyc(1);
        px = 10'd5; py = 10'd5;
        cyc(1);
    endtask

    // Origin plus a miss pulse presented in the same cycle as the tick.
    task automatic frame_miss(input logic l, input logic r);
        px = 10'd0; py = 10'd0;
        cyc(1);
        miss_l = l; miss_r = r;
        px = 10'd5; py = 10'd5;
        cyc(1);
        miss_l = 1'b0; miss_r = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc(3);
        start = 1'b0;
        cyc(2);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        px = 10'd5; py = 10'd5;
        cyc(3);
        chk("rst_state", state, S_IDLE);
        chk("rst_tick", tick, 0);
        chk("rst_run", run, 0);
        chk("rst_breset", breset, 1);
        chk("rst_scores", {score_l, score_r}, 0);
        chk("rst_winner", winner, 0);
        rst_n = 1'b1;
        cyc(2);

        // origin held for three cycles -> single tick
        px = 10'd0; py = 10'd0;
        chk("tick_pre", tick, 0);
        cyc(1);
        chk("tick_hi", tick, 1);
        cyc(1);
        chk("tick_lo1", tick, 0);
        cyc(1);
        chk("tick_lo2", tick, 0);
        px = 10'd5; py = 10'd5;
        cyc(1);

        // start latency: SERVE on the third edge
        start = 1'b1;
        cyc(2);
        chk("start_lat2", state, S_IDLE);
        cyc(1);
        chk("start_lat3", state, S_SERVE);
        start = 1'b0;
        cyc(2);
        chk("serve_run", run, 0);
        chk("serve_breset", breset, 1);

        frame();
        chk("serve_hold", state, S_SERVE);
        frame();
        chk("play_state", state, S_PLAY);
        chk("play_run", run, 1);
        chk("play_breset", breset, 0);

        // left misses -> right scores
        frame_miss(1'b1, 1'b0);
        chk("miss_l_score_r", score_r, 1);
        chk("miss_l_score_l", score_l, 0);
        chk("miss_l_state", state, S_POINT);
        chk("miss_l_run", run, 0);
        chk("miss_l_breset", breset, 1);
        frame(); frame();
        chk("point_hold", state, S_POINT);
        frame();
        chk("point_exit", state, S_SERVE);

        // miss during SERVE is ignored (its tick still counts)
        frame_miss(1'b1, 1'b0);
        chk("serve_miss_score", score_r, 1);
        chk("serve_miss_state", state, S_SERVE);
        frame();
        chk("play2_state", state, S_PLAY);

        // double miss -> replay, no score change
        frame_miss(1'b1, 1'b1);
        chk("dbl_state", state, S_POINT);
        chk("dbl_scores", {score_l, score_r}, {4'd0, 4'd1});
        frame(); frame(); frame();
        frame(); frame();
        chk("play3_state", state, S_PLAY);
        frame();

`ifdef MATCH_PAUSE_EN
        press_start();
        chk("pause_state", state, S_PAUSE);
        chk("pause_run", run, 0);
        chk("pause_breset", breset, 0);
        frame_miss(1'b1, 1'b0);
        chk("pause_miss_score", score_r, 1);
        chk("pause_miss_state", state, S_PAUSE);
        chk("pause_cnt_frozen", dut.frame_cnt, 1);
        press_start();
        chk("unpause_state", state, S_PLAY);
        chk("unpause_cnt", dut.frame_cnt, 1);
        chk("unpause_run", run, 1);
`else
        press_start();
        chk("play_start_ign", state, S_PLAY);
        chk("play_start_run", run, 1);
`endif

        // second right point wins the match
        frame_miss(1'b1, 1'b0);
        chk("win_score_r", score_r, 2);
        chk("win_point", state, S_POINT);
        frame(); frame(); frame();
        chk("over_state", state, S_OVER);
        chk("over_winner", winner, 2);
        chk("over_breset", breset, 1);
        chk("over_run", run, 0);
        frame_miss(1'b1, 1'b0);
        chk("over_sat", score_r, 2);
        chk("over_miss_state", state, S_OVER);
        press_start();
        chk("restart_state", state, S_SERVE);
        chk("restart_scores", {score_l, score_r}, 0);
        chk("restart_winner", winner, 0);

        // build some state, then reset mid-operation
        frame(); frame();
        frame_miss(1'b0, 1'b1);
        chk("right_miss_score_l", score_l, 1);
`ifdef MATCH_PAUSE_EN
        frame(); frame(); frame();
        frame(); frame();
        press_start();
        chk("pause2_state", state, S_PAUSE);
`endif
        px = 10'd0; py = 10'd0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, S_IDLE);
        chk("async_rst_score", score_l, 0);
        chk("async_rst_breset", breset, 1);
        cyc(3);
        chk("rst_no_tick", tick, 0);
        px = 10'd5; py = 10'd5;
        rst_n = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
